rf_wb_arbiter: RTL and testbench
================================

// Module: rf_wb_arbiter
// PURPOSE
//  Owns the single write port of the 32x64 integer register file (regs). After reset it runs an
//  init sequence writing zero to x1..x31; it then arbitrates between two write-back requesters
//  (EXU result, LSU load data) with valid/ready handshakes and round-robin fairness.
//  Sits between the EXU/LSU write-back stages and regs.wen/waddr/wdata.
// PARAMETERS
//  XLEN  64  data width of a register
//  AW    5   register address width
//  NREG  32  number of architectural registers (x0 hardwired zero, never written)
// PORTS
//  clk        in   1     clock; all state updates on rising edge
//  rst        in   1     reset, asynchronous, active-high
//  exu_valid  in   1     EXU write-back request
//  exu_ready  out  1     EXU request accepted this cycle when exu_valid & exu_ready
//  exu_rd     in   AW    EXU destination register
//  exu_data   in   XLEN  EXU write data
//  lsu_valid  in   1     LSU write-back request
//  lsu_ready  out  1     LSU request accepted this cycle when lsu_valid & lsu_ready
//  lsu_rd     in   AW    LSU destination register
//  lsu_data   in   XLEN  LSU write data
//  rf_wen     out  1     to regs.wen (registered)
//  rf_waddr   out  AW    to regs.waddr (registered)
//  rf_wdata   out  XLEN  to regs.wdata (registered)
//  init_done  out  1     high once init sequence has issued its last write (state RUN)
// BEHAVIOUR
//  Reset (async, immediate): state=INIT, cnt=1, rr_last=LSU; rf_wen=0, rf_waddr=0, rf_wdata=0,
//   init_done=0, exu_ready=0, lsu_ready=0. Reset mid-init or mid-run aborts and restarts INIT;
//   a request presented during reset is not accepted and must be held by its requester.
//  INIT: each edge registers rf_wen=1, rf_waddr=cnt, rf_wdata=0, cnt<=cnt+1; the edge issuing
//   cnt==NREG-1 also moves state to RUN. Exactly NREG-1 (31) writes, addresses 1..31 ascending,
//   on consecutive cycles. Both ready outputs held 0 throughout INIT.
//  RUN: init_done=1. Grant is combinational from valids and rr_last:
//   only one valid -> grant it; both valid -> grant the one not equal rr_last; none -> no grant.
//   exu_ready/lsu_ready = respective grant (never both high). Ready never asserted without valid.
//  Accept edge: rr_last<=granted source; rf_wen<=(rd!=0); rf_waddr<=rd; rf_wdata<=data.
//   Latency: accepted request appears on rf_* one cycle after the accept edge; regs writes it
//   at the following edge. Throughput 1 write/cycle, no bubbles under continuous traffic.
//  No accept edge: rf_wen<=0; rf_waddr/rf_wdata hold previous values.
//  rd==0: request is accepted (ready=1, rr_last updates) but rf_wen stays 0 -> x0 never written.
//  Both valid with same rd: served in grant order, later one wins in regs (program order is the
//   requesters' responsibility; this block does not reorder or merge).
//  Requester protocol: once valid is high, valid/rd/data stay stable until accepted; the
//   arbiter does not latch unaccepted requests. A loser keeps valid and wins next cycle.
//  No internal buffering beyond the output register; no backpressure from regs (always ready).
// TESTING
//  1 Release rst, no requests -> rf_wen=1 for 31 cycles, rf_waddr 1..31, rf_wdata=0; then
//    init_done=1, rf_wen=0.
//  2 exu_valid held from INIT start, exu_rd=5, exu_data=0xDEAD -> exu_ready=0 until RUN; first
//    RUN cycle accepts; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0xDEAD; write 31 precedes it.
//  3 RUN, both valid continuously (exu_rd=3, lsu_rd=4) -> grants alternate EXU,LSU,EXU...
//    (rr_last=LSU at reset so EXU first); rf_waddr alternates 3,4,3 with rf_wen=1 every cycle.
//  4 RUN, lsu_valid with lsu_rd=0, lsu_data=0xFF -> lsu_ready=1, next cycle rf_wen=0; then
//    exu_rd=0 & lsu_rd=7 both valid -> EXU granted first (rr_last=LSU), LSU next; x7 written.
//  5 Assert rst asynchronously mid-RUN while lsu_valid high -> rf_wen, readies, init_done drop
//    immediately; after release INIT repeats 31 writes before lsu request is accepted.
//  6 Assert rst at INIT cnt=17 -> after release rf_waddr restarts at 1, not 18.

Source files
------------

// File: rtl/rf_wb_arbiter_if.sv
// Write-back request bundle (EXU, LSU) and register-file write port.
// master drives requests and observes the RF port; slave is the arbiter.
interface rf_wb_arbiter_if #(
  parameter int XLEN = 64,
  parameter int AW   = 5
);
  logic            exu_valid;
  logic            exu_ready;
  logic [AW-1:0]   exu_rd;
  logic [XLEN-1:0] exu_data;
  logic            lsu_valid;
  logic            lsu_ready;
  logic [AW-1:0]   lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            rf_wen;
  logic [AW-1:0]   rf_waddr;
  logic [XLEN-1:0] rf_wdata;
  logic            init_done;

  modport master (
    output exu_valid, exu_rd, exu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  exu_ready, lsu_ready,
    input  rf_wen, rf_waddr, rf_wdata, init_done
  );

  modport slave (
    input  exu_valid, exu_rd, exu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output exu_ready, lsu_ready,
    output rf_wen, rf_waddr, rf_wdata, init_done
  );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Owns the register-file write port: zero-fills x1..x(NREG-1) after reset, then
// round-robin arbitrates EXU/LSU write-backs; one registered write per cycle.
module rf_wb_arbiter #(
  parameter int XLEN = 64,
  parameter int AW   = 5,
  parameter int NREG = 32
) (
  input  logic               clk,
  input  logic               rst,
  rf_wb_arbiter_if.slave     wb
);

  typedef enum logic {S_INIT, S_RUN} state_e;

  localparam logic SRC_EXU = 1'b0;
  localparam logic SRC_LSU = 1'b1;

  state_e          state_q,    state_d;
  logic [AW-1:0]   cnt_q,      cnt_d;
  logic            rr_last_q,  rr_last_d;
  logic            rf_wen_q,   rf_wen_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            gnt_exu;
  logic            gnt_lsu;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_INIT;
      cnt_q      <= AW'(1);
      rr_last_q  <= SRC_LSU;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rr_last_q  <= rr_last_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rr_last_d  = rr_last_q;
    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    case (state_q)
      S_INIT: begin
        rf_wen_d   = 1'b1;
        rf_waddr_d = cnt_q;
        rf_wdata_d = '0;
        cnt_d      = cnt_q + AW'(1);
        if (cnt_q == AW'(NREG - 1)) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        // rd==0 is still consumed so the requester retires, but x0 is never written
        if (gnt_exu) begin
          rr_last_d  = SRC_EXU;
          rf_wen_d   = (wb.exu_rd != '0);
          rf_waddr_d = wb.exu_rd;
          rf_wdata_d = wb.exu_data;
        end else if (gnt_lsu) begin
          rr_last_d  = SRC_LSU;
          rf_wen_d   = (wb.lsu_rd != '0);
          rf_waddr_d = wb.lsu_rd;
          rf_wdata_d = wb.lsu_data;
        end
      end
      default: state_d = S_INIT;
    endcase
  end

  always_comb begin
    gnt_exu = 1'b0;
    gnt_lsu = 1'b0;
    if (state_q == S_RUN) begin
      gnt_exu = wb.exu_valid && (!wb.lsu_valid || (rr_last_q == SRC_LSU));
      gnt_lsu = wb.lsu_valid && (!wb.exu_valid || (rr_last_q == SRC_EXU));
    end
  end

  assign wb.exu_ready = gnt_exu;
  assign wb.lsu_ready = gnt_lsu;
  assign wb.rf_wen    = rf_wen_q;
  assign wb.rf_waddr  = rf_waddr_q;
  assign wb.rf_wdata  = rf_wdata_q;
  assign wb.init_done = (state_q == S_RUN);

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter: init sweep, grant ordering, x0 suppression, async reset.
module tb_rf_wb_arbiter;
  logic clk;
  logic rst;
  int   n_run;
  int   n_fail;

  rf_wb_arbiter_if #(.XLEN(64), .AW(5)) wb ();

  rf_wb_arbiter #(.XLEN(64), .AW(5), .NREG(32)) dut (
    .clk (clk),
    .rst (rst),
    .wb  (wb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic idle_reqs();
    wb.exu_valid = 1'b0;
    wb.exu_rd    = '0;
    wb.exu_data  = '0;
    wb.lsu_valid = 1'b0;
    wb.lsu_rd    = '0;
    wb.lsu_data  = '0;
  endtask

  initial begin
    n_run  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle_reqs();

    // reset state
    @(negedge clk);
    check("rst_wen",   64'(wb.rf_wen),    64'd0);
    check("rst_waddr", 64'(wb.rf_waddr),  64'd0);
    check("rst_wdata", wb.rf_wdata,       64'd0);
    check("rst_done",  64'(wb.init_done), 64'd0);
    check("rst_erdy",  64'(wb.exu_ready), 64'd0);
    check("rst_lrdy",  64'(wb.lsu_ready), 64'd0);

    // 1: init sweep, no requests
    rst = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      check("init_wen",   64'(wb.rf_wen),    64'd1);
      check("init_waddr", 64'(wb.rf_waddr),  64'(i));
      check("init_wdata", wb.rf_wdata,       64'd0);
      check("init_done",  64'(wb.init_done), (i == 31) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    check("post_init_wen",  64'(wb.rf_wen),    64'd0);
    check("post_init_done", 64'(wb.init_done), 64'd1);

    // 2: EXU request held from INIT start
    wb.exu_valid = 1'b1;
    wb.exu_rd    = 5'd5;
    wb.exu_data  = 64'hDEAD;
    do_reset();
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      check("t2_waddr", 64'(wb.rf_waddr),  64'(i));
      check("t2_erdy",  64'(wb.exu_ready), (i == 31) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    check("t2_wen",   64'(wb.rf_wen),   64'd1);
    check("t2_waddr5", 64'(wb.rf_waddr), 64'd5);
    check("t2_wdata", wb.rf_wdata,      64'hDEAD);
    idle_reqs();
    @(negedge clk);
    check("t2_idle_wen", 64'(wb.rf_wen), 64'd0);

    // 3: both valid continuously, alternating from EXU
    do_reset();
    repeat (31) @(negedge clk);
    wb.exu_valid = 1'b1; wb.exu_rd = 5'd3; wb.exu_data = 64'h33;
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd4; wb.lsu_data = 64'h44;
    for (int k = 0; k < 6; k++) begin
      #1;
      check("t3_erdy", 64'(wb.exu_ready), (k % 2 == 0) ? 64'd1 : 64'd0);
      check("t3_lrdy", 64'(wb.lsu_ready), (k % 2 == 0) ? 64'd0 : 64'd1);
      @(negedge clk);
      check("t3_wen",   64'(wb.rf_wen),   64'd1);
      check("t3_waddr", 64'(wb.rf_waddr), (k % 2 == 0) ? 64'd3 : 64'd4);
      check("t3_wdata", wb.rf_wdata,      (k % 2 == 0) ? 64'h33 : 64'h44);
    end
    idle_reqs();

    // 4: rd==0 accepted without a write; EXU first after LSU
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd0; wb.lsu_data = 64'hFF;
    #1;
    check("t4_lrdy0", 64'(wb.lsu_ready), 64'd1);
    check("t4_erdy0", 64'(wb.exu_ready), 64'd0);
    @(negedge clk);
    check("t4_x0_wen", 64'(wb.rf_wen), 64'd0);
    wb.exu_valid = 1'b1; wb.exu_rd = 5'd0; wb.exu_data = 64'hE0;
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd7; wb.lsu_data = 64'h77;
    #1;
    check("t4_erdy", 64'(wb.exu_ready), 64'd1);
    check("t4_lrdy", 64'(wb.lsu_ready), 64'd0);
    @(negedge clk);
    check("t4_x0e_wen", 64'(wb.rf_wen), 64'd0);
    wb.exu_valid = 1'b0;
    #1;
    check("t4_lrdy7", 64'(wb.lsu_ready), 64'd1);
    @(negedge clk);
    check("t4_x7_wen",   64'(wb.rf_wen),   64'd1);
    check("t4_x7_waddr", 64'(wb.rf_waddr), 64'd7);
    check("t4_x7_wdata", wb.rf_wdata,      64'h77);
    idle_reqs();
    @(negedge clk);
    check("t4_hold_wen",   64'(wb.rf_wen),   64'd0);
    check("t4_hold_waddr", 64'(wb.rf_waddr), 64'd7);
    check("t4_hold_wdata", wb.rf_wdata,      64'h77);

    // 5: async reset mid-RUN with LSU pending
    wb.exu_valid = 1'b1; wb.exu_rd = 5'd2; wb.exu_data = 64'h22;
    @(negedge clk);
    check("t5_wen_pre", 64'(wb.rf_wen), 64'd1);
    wb.exu_valid = 1'b0;
    wb.lsu_valid = 1'b1; wb.lsu_rd = 5'd9; wb.lsu_data = 64'h99;
    #1;
    check("t5_lrdy_pre", 64'(wb.lsu_ready), 64'd1);
    #1;
    rst = 1'b1;
    #1;
    check("t5_rst_wen",  64'(wb.rf_wen),    64'd0);
    check("t5_rst_lrdy", 64'(wb.lsu_ready), 64'd0);
    check("t5_rst_done", 64'(wb.init_done), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      check("t5_waddr", 64'(wb.rf_waddr),  64'(i));
      check("t5_lrdy",  64'(wb.lsu_ready), (i == 31) ? 64'd1 : 64'd0);
    end
    @(negedge clk);
    check("t5_wen",   64'(wb.rf_wen),   64'd1);
    check("t5_waddr9", 64'(wb.rf_waddr), 64'd9);
    check("t5_wdata", wb.rf_wdata,      64'h99);
    idle_reqs();

    // 6: reset while INIT has cnt==17 restarts the sweep at 1
    do_reset();
    repeat (16) @(negedge clk);
    check("t6_waddr16", 64'(wb.rf_waddr), 64'd16);
    rst = 1'b1;
    #1;
    check("t6_rst_wen", 64'(wb.rf_wen), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t6_wen",   64'(wb.rf_wen),   64'd1);
    check("t6_waddr", 64'(wb.rf_waddr), 64'd1);
    @(negedge clk);
    check("t6_waddr2", 64'(wb.rf_waddr), 64'd2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: run did not complete, got %0d checks expected completion", n_run);
    $fatal(1);
  end
endmodule
